// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, one-cycle data_valid / frame_err strobes.
// Optional `UART_RX_MAJORITY_EN: 2-of-3 vote per bit. rx-low to data_valid = 4+HALF_TICKS+9*(BIT_TICKS+1) clk (+1 with vote).
module uart_rx #(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD       = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_err,
    output logic       busy,
    output logic [2:0] dbg_state_o
);

    localparam int BIT_TICKS  = CLOCK_FREQ / BAUD;
    localparam int HALF_TICKS = (BIT_TICKS + 1) / 2;
    localparam int CW         = $clog2(BIT_TICKS + 2);
    localparam logic [CW-1:0] HALF_LD = CW'(HALF_TICKS);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      data_q, data_d;
    logic            dv_q, dv_d;
    logic            fe_q, fe_d;
    logic            rx_meta_q, rx_s_q;
    logic            sample_now;
    logic            sample_bit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    // Decision lands one cycle after cnt==0, so reload one short to keep the bit period.
    localparam logic [CW-1:0] RELOAD = CW'(BIT_TICKS - 1);
    logic m1_q, m0_q, pend_q;
    logic counting;

    assign counting   = (state_q == S_START) || (state_q == S_DATA) || (state_q == S_STOP);
    assign sample_now = pend_q;
    assign sample_bit = (m1_q & m0_q) | (m1_q & rx_s_q) | (m0_q & rx_s_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m1_q   <= 1'b0;
            m0_q   <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            pend_q <= 1'b0;
            if (counting) begin
                if (cnt_q == CW'(1)) m1_q <= rx_s_q;
                if (cnt_q == '0 && !pend_q) begin
                    m0_q   <= rx_s_q;
                    pend_q <= 1'b1;
                end
            end
        end
    end
`else
    localparam logic [CW-1:0] RELOAD = CW'(BIT_TICKS);
    assign sample_now = (cnt_q == '0);
    assign sample_bit = rx_s_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            data_q  <= 8'h00;
            dv_q    <= 1'b0;
            fe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            dv_q    <= dv_d;
            fe_q    <= fe_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        dv_d    = 1'b0;
        fe_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!rx_s_q) begin
                    cnt_d   = HALF_LD;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (sample_now) begin
                    if (sample_bit) begin
                        state_d = S_IDLE;
                    end else begin
                        cnt_d   = RELOAD;
                        bit_d   = 3'd0;
                        state_d = S_DATA;
                    end
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_DATA: begin
                if (sample_now) begin
                    shift_d[bit_q] = sample_bit;
                    cnt_d          = RELOAD;
                    if (bit_q == 3'd7) state_d = S_STOP;
                    else               bit_d   = bit_q + 3'd1;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_STOP: begin
                if (sample_now) begin
                    if (sample_bit) begin
                        data_d  = shift_q;
                        dv_d    = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        fe_d    = 1'b1;
                        state_d = S_BREAK;
                    end
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_BREAK: begin
                // Held-low line: wait for idle so a break never looks like more frames.
                if (rx_s_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy        = (state_q != S_IDLE);
        dbg_state_o = state_q;
        data_out    = data_q;
        data_valid  = dv_q;
        frame_err   = fe_q;
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 1 MHz / 100 kbaud (11-cycle bit period).
// Scenario tasks compare inline; a negedge monitor logs strobes and received bytes.
module tb_uart_rx;

    localparam int BITP = 11;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       busy;
    logic [2:0] dbg_state;

    int pass_cnt  = 0;
    int total_cnt = 0;

    uart_rx #(.CLOCK_FREQ(1_000_000), .BAUD(100_000)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx          (rx),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .frame_err   (frame_err),
        .busy        (busy),
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;

    // Monitor
    int         cyc = 0, dv_cnt = 0, fe_cnt = 0, both_cnt = 0, busy_cyc = 0;
    int         last_dv_cyc = 0, last_fall_cyc = 0;
    logic       prev_busy = 1'b0;
    logic [7:0] got_mem [64];
    logic [7:0] exp_q [$];

    always @(negedge clk) begin
        cyc       <= cyc + 1;
        prev_busy <= busy;
        if (busy) busy_cyc <= busy_cyc + 1;
        if (prev_busy && !busy) last_fall_cyc <= cyc;
        if (data_valid) begin
            if (dv_cnt < 64) got_mem[dv_cnt] <= data_out;
            dv_cnt      <= dv_cnt + 1;
            last_dv_cyc <= cyc;
        end
        if (frame_err) fe_cnt <= fe_cnt + 1;
        if (data_valid && frame_err) both_cnt <= both_cnt + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got %0d/%0d checks", pass_cnt, total_cnt);
        $fatal(1, "watchdog");
    end

    task automatic drive_bit(input logic v);
        rx = v;
        repeat (BITP) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop_bit);
    endtask

    task automatic test_reset();
        int dv0, fe0, bc0;
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total_cnt++; if (data_out !== 8'h00) $display("FAIL reset_data_out: got %h want 00", data_out); else pass_cnt++;
        total_cnt++; if (data_valid !== 1'b0) $display("FAIL reset_data_valid: got %b want 0", data_valid); else pass_cnt++;
        total_cnt++; if (frame_err !== 1'b0) $display("FAIL reset_frame_err: got %b want 0", frame_err); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
        dv0 = dv_cnt; fe0 = fe_cnt; bc0 = busy_cyc;
        repeat (100) @(negedge clk);
        total_cnt++; if (dv_cnt - dv0 !== 0) $display("FAIL idle_dv: got %0d pulses want 0", dv_cnt - dv0); else pass_cnt++;
        total_cnt++; if (fe_cnt - fe0 !== 0) $display("FAIL idle_fe: got %0d pulses want 0", fe_cnt - fe0); else pass_cnt++;
        total_cnt++; if (busy_cyc - bc0 !== 0) $display("FAIL idle_busy: got %0d busy cycles want 0", busy_cyc - bc0); else pass_cnt++;
        total_cnt++; if (data_out !== 8'h00) $display("FAIL idle_data_out: got %h want 00", data_out); else pass_cnt++;
    endtask

    task automatic test_clean_a5();
        int dv0;
        dv0 = dv_cnt;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        repeat (20) @(negedge clk);
        total_cnt++; if (dv_cnt - dv0 !== 1) $display("FAIL a5_dv_count: got %0d want 1", dv_cnt - dv0); else pass_cnt++;
        for (int i = 0; exp_q.size() > 0; i++) begin
            logic [7:0] e;
            e = exp_q.pop_front();
            total_cnt++; if (got_mem[dv0 + i] !== e) $display("FAIL a5_byte: got %h want %h", got_mem[dv0 + i], e); else pass_cnt++;
        end
        total_cnt++; if (data_out !== 8'hA5) $display("FAIL a5_data_out: got %h want a5", data_out); else pass_cnt++;
        total_cnt++;
        if (last_fall_cyc - last_dv_cyc < 0 || last_fall_cyc - last_dv_cyc > 2)
            $display("FAIL a5_busy_fall: busy fell %0d cycles after valid, want 0..2", last_fall_cyc - last_dv_cyc);
        else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL a5_busy_end: got %b want 0", busy); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int dv0;
        dv0 = dv_cnt;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        repeat (20) @(negedge clk);
        total_cnt++; if (dv_cnt - dv0 !== 2) $display("FAIL b2b_dv_count: got %0d want 2", dv_cnt - dv0); else pass_cnt++;
        for (int i = 0; exp_q.size() > 0; i++) begin
            logic [7:0] e;
            e = exp_q.pop_front();
            total_cnt++; if (got_mem[dv0 + i] !== e) $display("FAIL b2b_byte%0d: got %h want %h", i, got_mem[dv0 + i], e); else pass_cnt++;
        end
    endtask

    task automatic test_frame_err();
        int dv0, fe0, n;
        dv0 = dv_cnt; fe0 = fe_cnt;
        send_frame(8'h3C, 1'b0);
        repeat (50) @(negedge clk);
        total_cnt++; if (fe_cnt - fe0 !== 1) $display("FAIL ferr_count: got %0d want 1", fe_cnt - fe0); else pass_cnt++;
        total_cnt++; if (dv_cnt - dv0 !== 0) $display("FAIL ferr_dv: got %0d want 0", dv_cnt - dv0); else pass_cnt++;
        total_cnt++; if (data_out !== 8'hFF) $display("FAIL ferr_data_out: got %h want ff", data_out); else pass_cnt++;
        total_cnt++; if (busy !== 1'b1) $display("FAIL ferr_break_busy: got %b want 1", busy); else pass_cnt++;
        rx = 1'b1;
        n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        total_cnt++; if (busy !== 1'b0) $display("FAIL ferr_release: busy %b after %0d cycles want 0", busy, n); else pass_cnt++;
        total_cnt++; if (fe_cnt - fe0 !== 1) $display("FAIL ferr_no_repeat: got %0d want 1", fe_cnt - fe0); else pass_cnt++;
        dv0 = dv_cnt;
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1);
        repeat (20) @(negedge clk);
        total_cnt++; if (dv_cnt - dv0 !== 1) $display("FAIL after_ferr_dv: got %0d want 1", dv_cnt - dv0); else pass_cnt++;
        for (int i = 0; exp_q.size() > 0; i++) begin
            logic [7:0] e;
            e = exp_q.pop_front();
            total_cnt++; if (got_mem[dv0 + i] !== e) $display("FAIL after_ferr_byte: got %h want %h", got_mem[dv0 + i], e); else pass_cnt++;
        end
    endtask

    task automatic test_glitch();
        int dv0, fe0, bc0;
        dv0 = dv_cnt; fe0 = fe_cnt; bc0 = busy_cyc;
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (30) @(negedge clk);
        total_cnt++; if (busy_cyc - bc0 <= 0) $display("FAIL glitch_busy_pulse: got %0d busy cycles want >0", busy_cyc - bc0); else pass_cnt++;
        total_cnt++; if (dv_cnt - dv0 !== 0) $display("FAIL glitch_dv: got %0d want 0", dv_cnt - dv0); else pass_cnt++;
        total_cnt++; if (fe_cnt - fe0 !== 0) $display("FAIL glitch_fe: got %0d want 0", fe_cnt - fe0); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL glitch_idle: got %b want 0", busy); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        logic [7:0] b;
        int dv0;
        b = 8'h5A;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(b[i]);
        total_cnt++; if (busy !== 1'b1) $display("FAIL rstmid_pre_busy: got %b want 1", busy); else pass_cnt++;
        rst = 1'b1;
        #1;
        total_cnt++; if (data_out !== 8'h00) $display("FAIL rstmid_data_out: got %h want 00", data_out); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (data_valid !== 1'b0 || frame_err !== 1'b0) $display("FAIL rstmid_strobes: got %b%b want 00", data_valid, frame_err); else pass_cnt++;
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        dv0 = dv_cnt;
        repeat (20) @(negedge clk);
        total_cnt++; if (dv_cnt - dv0 !== 0 || busy !== 1'b0) $display("FAIL rstmid_discard: got %0d pulses busy %b want 0 0", dv_cnt - dv0, busy); else pass_cnt++;
        exp_q.push_back(8'hC3);
        send_frame(8'hC3, 1'b1);
        repeat (20) @(negedge clk);
        total_cnt++; if (dv_cnt - dv0 !== 1) $display("FAIL rstmid_c3_dv: got %0d want 1", dv_cnt - dv0); else pass_cnt++;
        for (int i = 0; exp_q.size() > 0; i++) begin
            logic [7:0] e;
            e = exp_q.pop_front();
            total_cnt++; if (got_mem[dv0 + i] !== e) $display("FAIL rstmid_c3_byte: got %h want %h", got_mem[dv0 + i], e); else pass_cnt++;
        end
    endtask

`ifdef UART_RX_MAJORITY_EN
    task automatic test_majority();
        logic [7:0] b;
        int dv0;
        b = 8'h96;
        dv0 = dv_cnt;
        exp_q.push_back(8'h96);
        drive_bit(1'b0);
        // One inverted cycle centred in each data bit's sampling window.
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (6) @(negedge clk);
            rx = ~b[i];
            @(negedge clk);
            rx = b[i];
            repeat (4) @(negedge clk);
        end
        drive_bit(1'b1);
        repeat (20) @(negedge clk);
        total_cnt++; if (dv_cnt - dv0 !== 1) $display("FAIL maj_dv: got %0d want 1", dv_cnt - dv0); else pass_cnt++;
        for (int i = 0; exp_q.size() > 0; i++) begin
            logic [7:0] e;
            e = exp_q.pop_front();
            total_cnt++; if (got_mem[dv0 + i] !== e) $display("FAIL maj_byte: got %h want %h", got_mem[dv0 + i], e); else pass_cnt++;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_clean_a5();
        test_back_to_back();
        test_frame_err();
        test_glitch();
        test_reset_mid();
`ifdef UART_RX_MAJORITY_EN
        test_majority();
`endif
        total_cnt++; if (both_cnt !== 0) $display("FAIL exclusive_strobes: got %0d overlap cycles want 0", both_cnt); else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Asynchronous serial receiver for 8N1 frames: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); line idles high.
- Sits at the host-to-FPGA end of the UART link and feeds received bytes to the command/operand loader of the linear-layer accelerator.
- Oversamples the line with the system clock, samples at mid-bit, delivers each byte with a one-cycle valid strobe and reports framing errors.

Parameters:
- CLOCK_FREQ, 50_000_000, system clock frequency in Hz.
- BAUD, 115200, UART baud rate.
- Derived localparams:
  - BIT_TICKS = CLOCK_FREQ / BAUD.
  - One bit period = BIT_TICKS+1 clk cycles.
  - HALF_TICKS = (BIT_TICKS+1)/2, integer division.
  - Tick counter width = $clog2(BIT_TICKS+2).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- rx  input  1  serial input; asynchronous to clk; idle = 1.
- data_out  output  8  last correctly received byte; held until the next good frame.
- data_valid  output  1  one-cycle pulse when data_out is updated.
- frame_err  output  1  one-cycle pulse when the stop bit samples 0.
- busy  output  1  high from start-bit detection until return to IDLE.

Behaviour:
- Reset (asynchronous, any state, including mid-frame):
  - data_out = 8'h00; data_valid = 0; frame_err = 0; busy = 0.
  - Both synchronizer flops = 1; state = IDLE; counters = 0.
  - Any partial frame is discarded.
- Input synchronizer: rx passes through 2 flops (rx_s). All decisions use rx_s. Synchronizer latency is 2 cycles.
- IDLE:
  - busy = 0.
  - When rx_s = 0: load tick counter with HALF_TICKS, set busy = 1, go to START.
- START:
  - Count down to 0, then sample rx_s.
  - rx_s = 1: false start (glitch). Go to IDLE with no strobe.
  - rx_s = 0: load BIT_TICKS, clear bit_cnt, go to DATA.
- DATA:
  - Count down to 0, then shift rx_s into bit[bit_cnt] of the shift register (LSB first) and reload BIT_TICKS.
  - When bit_cnt = 7 is sampled, go to STOP. Otherwise increment bit_cnt.
  - bit_cnt is 3 bits and does not wrap past 7.
- STOP:
  - Count down to 0, then sample rx_s.
  - rx_s = 1: data_out <= shift register; data_valid pulses for exactly 1 cycle; go to IDLE.
  - rx_s = 0: frame_err pulses for 1 cycle; data_out is unchanged; go to BREAK.
- BREAK:
  - busy stays 1. Wait until rx_s = 1, then go to IDLE.
  - A held-low line (break condition) never generates repeated frames.
- Back-to-back frames:
  - A new start bit is detectable on the cycle after the STOP→IDLE transition.
  - Receiver returns to IDLE at mid-stop-bit, so no idle gap is required between frames.
- data_valid and frame_err are never high in the same cycle.
- Latency: from rx falling edge to data_valid = 2 + 1 + HALF_TICKS + 9*(BIT_TICKS+1) + small fixed FSM overhead (≤3 cycles). The exact count is fixed per implementation and documented in the header.
- rx transitions during the count-down between samples are ignored.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined:
  - Every bit decision (start, data, stop) is the 2-of-3 majority of rx_s captured at tick counter values 1, 0 and the cycle after 0.
  - State transitions are delayed by that one extra cycle, so the bit period is unchanged and overhead is +1 cycle per bit.
  - A single-cycle glitch at mid-bit cannot flip a bit.
- Undefined: single sample at tick counter = 0, exactly as described in Behaviour.

Test Plan (CLOCK_FREQ=1_000_000, BAUD=100_000 → bit period 11 cycles):
- Reset then idle rx=1 for 100 cycles → data_out=00, data_valid/frame_err/busy stay 0.
- Send 8'hA5 as a clean frame → exactly one data_valid pulse, data_out=A5, busy falls within 2 cycles after.
- Send 8'h00 then 8'hFF back-to-back with no idle gap → two data_valid pulses, values 00 then FF.
- Send frame 8'h3C with stop bit forced 0, then hold rx=0 for 50 cycles, then release → one frame_err pulse, data_out unchanged, no data_valid; next frame 8'h81 is received correctly.
- rx low pulse of 3 cycles while idle → busy pulses, no data_valid and no frame_err, returns to IDLE.
- Assert rst mid-DATA of frame 8'h5A → outputs return to reset values immediately; after release, next frame 8'hC3 is received correctly. With UART_RX_MAJORITY_EN, a 1-cycle glitch injected at each mid-bit of 8'h96 still yields 96.
